main_blink: RTL and testbench

- Free-running LED blinker for the 12 MHz board clock.
- Divides CLK by a parameterised count and toggles LED1 once every N rising edges.
- LED2 is always the complement of LED1.
- Top-level leaf block: it drives board LED pins directly and has no upstream handshake.

---
 rtl/blink_pkg.sv | 12 +
 rtl/main_blink_if.sv | 8 +
 rtl/tick_divider.sv | 31 +++
 rtl/main_blink.sv | 40 ++++
 tb/tb_main_blink.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared constants and helpers for the board LED blinker.
package blink_pkg;

  localparam int unsigned CLK_HZ            = 12000000;
  localparam int unsigned BLINK_HALF_PERIOD = CLK_HZ / 2;

  // Counter width for a divide-by-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/main_blink_if.sv
// LED pin bundle; master drives the pins, slave observes them.
interface main_blink_if;
  logic LED1;
  logic LED2;

  modport master (output LED1, output LED2);
  modport slave  (input  LED1, input  LED2);
endinterface

// File: rtl/tick_divider.sv
// Free-running divide-by-N counter emitting a one-cycle tick on its last count.
module tick_divider
  import blink_pkg::*;
#(
  parameter int unsigned N = BLINK_HALF_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int unsigned    CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  // Declaration value gives the same start state without a reset pulse.
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;

  // Explicit compare against N-1 so power-of-two N never relies on overflow.
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/main_blink.sv
// LED blinker: LED1 toggles every N clock edges, LED2 is its complement.
module main_blink
  import blink_pkg::*;
#(
  parameter int unsigned N = BLINK_HALF_PERIOD
) (
  input  logic CLK,
  input  logic RST,
  output logic LED1,
  output logic LED2
);

  logic tick;
  logic led_q = 1'b0;
  logic led_d;

  tick_divider #(.N(N)) u_div (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  // Flip the LED level on each divider tick.
  always_comb begin
    led_d = led_q ^ tick;
  end

  // LED level register, cleared asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) led_q <= 1'b0;
    else     led_q <= led_d;
  end

  // Both pins come straight from the one register.
  always_comb begin
    LED1 = led_q;
    LED2 = ~led_q;
  end

endmodule

// File: tb/tb_main_blink.sv
// Bench for main_blink at several divide ratios.
module tb_main_blink;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3 = 1'b0;
  logic rst1 = 1'b1;
  logic rst4 = 1'b1;
  logic rstd = 1'b1;

  main_blink_if if3 ();
  main_blink_if if1 ();
  main_blink_if if4 ();
  main_blink_if ifd ();

  main_blink #(.N(3)) u3 (.CLK(clk), .RST(rst3), .LED1(if3.LED1), .LED2(if3.LED2));
  main_blink #(.N(1)) u1 (.CLK(clk), .RST(rst1), .LED1(if1.LED1), .LED2(if1.LED2));
  main_blink #(.N(4)) u4 (.CLK(clk), .RST(rst4), .LED1(if4.LED1), .LED2(if4.LED2));
  main_blink          ud (.CLK(clk), .RST(rstd), .LED1(ifd.LED1), .LED2(ifd.LED2));

  int tests_run    = 0;
  int tests_failed = 0;
  bit exp_q[$];

  function automatic logic get_led1(input int sel);
    case (sel)
      1:       return if1.LED1;
      3:       return if3.LED1;
      4:       return if4.LED1;
      default: return ifd.LED1;
    endcase
  endfunction

  function automatic logic get_led2(input int sel);
    case (sel)
      1:       return if1.LED2;
      3:       return if3.LED2;
      4:       return if4.LED2;
      default: return ifd.LED2;
    endcase
  endfunction

  // Expected LED1 after k edges is bit 0 of k/n; samples taken after the falling edge.
  task automatic run_pattern(input int sel, input int n, input int count, input string name);
    for (int k = 0; k < count; k++) exp_q.push_back(((k / n) % 2) == 1);
    for (int k = 0; k < count; k++) begin
      bit   e;
      logic a1, a2;
      if (k > 0) @(negedge clk);
      e  = exp_q.pop_front();
      a1 = get_led1(sel);
      a2 = get_led2(sel);
      tests_run++;
      if (a1 !== e) begin
        tests_failed++;
        $display("FAIL %s_led1[%0d]: got %b expected %b", name, k, a1, e);
      end
      tests_run++;
      if (a2 !== ~e) begin
        tests_failed++;
        $display("FAIL %s_led2[%0d]: got %b expected %b", name, k, a2, ~e);
      end
      if (sel == 4) begin
        tests_run++;
        if (u4.u_div.cnt_q !== 2'(k % 4)) begin
          tests_failed++;
          $display("FAIL %s_cnt[%0d]: got %0d expected %0d", name, k, u4.u_div.cnt_q, k % 4);
        end
      end
    end
  endtask

  task automatic check_leds(input int sel, input logic e1, input string name);
    logic a1, a2;
    a1 = get_led1(sel);
    a2 = get_led2(sel);
    tests_run++;
    if (a1 !== e1 || a2 !== ~e1) begin
      tests_failed++;
      $display("FAIL %s: got LED1=%b LED2=%b expected LED1=%b LED2=%b", name, a1, a2, e1, ~e1);
    end
  endtask

  task automatic test_power_up;
    #1;
    run_pattern(3, 3, 12, "powerup");
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst3 = 1'b1;
    #1 check_leds(3, 1'b0, "reset_enter");
    repeat (2) begin
      @(negedge clk);
      check_leds(3, 1'b0, "reset_hold");
    end
    rst3 = 1'b0;
    run_pattern(3, 3, 12, "after_reset");
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    repeat (4) @(negedge clk);
    check_leds(3, 1'b1, "pre_async_high");
    #2 rst3 = 1'b1;
    #1 check_leds(3, 1'b0, "async_clear");
    #1 rst3 = 1'b0;
    run_pattern(3, 3, 4, "async_release");
  endtask

  task automatic test_n1;
    @(negedge clk);
    rst1 = 1'b0;
    run_pattern(1, 1, 6, "n1");
  endtask

  task automatic test_pow2;
    @(negedge clk);
    rst4 = 1'b0;
    run_pattern(4, 4, 16, "n4");
  endtask

  task automatic test_default;
    int bad;
    bad = 0;
    check_leds(0, 1'b0, "default_reset");
    @(negedge clk);
    rstd = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (ifd.LED1 !== 1'b0 || ifd.LED2 !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL default_hold: %0d samples toggled early, expected 0", bad);
    end
    tests_run++;
    if (ud.u_div.cnt_q !== 23'd200) begin
      tests_failed++;
      $display("FAIL default_cnt: got %0d expected 200", ud.u_div.cnt_q);
    end
    #2 rstd = 1'b1;
    #1;
    tests_run++;
    if (ud.u_div.cnt_q !== 23'd0) begin
      tests_failed++;
      $display("FAIL default_async_clear: got %0d expected 0", ud.u_div.cnt_q);
    end
  endtask

  initial begin
    test_power_up();
    test_reset();
    test_async_reset();
    test_n1();
    test_pow2();
    test_default();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
